// File: rtl/dynamic_scan_controller.sv
// -----------------------------------------------------------------------------
// dynamic_scan_controller
//
// Time-multiplexes one segment bus across DIGITS common anodes. Each digit owns
// a slot of DIV clock cycles. The first BLANK cycles of every slot drive all
// outputs inactive so the previous digit's pattern cannot ghost onto the next
// anode. Segment data is captured into a shadow register once per frame, so a
// frame never shows a mix of old and new data.
//
// Ports
//   CLK        system clock, all logic on the rising edge
//   RST        synchronous reset, active-high
//   DIGIT_EN   per-digit enable, sampled live (a disabled digit stays blank)
//   SEG_IN     segment data, digit i at [i*SEG_W +: SEG_W]
//   SEL        binary index of the digit currently being scanned
//   ANODE      anode drive, at most one digit asserted (per ANODE_ACTIVE_LOW)
//   SEG_OUT    segment drive for the current digit (per SEG_ACTIVE_LOW)
//   FRAME_STB  one-cycle pulse on the first cycle of each new frame
// -----------------------------------------------------------------------------
module dynamic_scan_controller #(
    parameter int DIGITS           = 4,
    parameter int DIV              = 20000,
    parameter int BLANK            = 1000,
    parameter int SEG_W            = 8,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DIGITS-1:0]          DIGIT_EN,
    input  logic [DIGITS*SEG_W-1:0]    SEG_IN,
    output logic [$clog2(DIGITS)-1:0]  SEL,
    output logic [DIGITS-1:0]          ANODE,
    output logic [SEG_W-1:0]           SEG_OUT,
    output logic                       FRAME_STB
);

    localparam int SW = $clog2(DIGITS);
    localparam int CW = $clog2(DIV);

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    localparam logic [SW-1:0] SEL_MAX = SW'(DIGITS - 1);

    localparam logic [DIGITS-1:0] ANODE_IDLE = {DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]  SEG_IDLE   = {SEG_W{SEG_ACTIVE_LOW}};

    logic [CW-1:0]           cnt, cnt_nxt;
    logic [SW-1:0]           sel, sel_nxt;
    logic [DIGITS*SEG_W-1:0] shadow, shadow_nxt;
    logic                    frame_edge;
    logic                    blank_nxt;
    logic [DIGITS-1:0]       anode_nxt;
    logic [SEG_W-1:0]        seg_lit;
    logic [SEG_W-1:0]        seg_nxt;

    assign SEL = sel;

    // Outputs are derived from the next-state values so that, after every
    // edge, ANODE and SEG_OUT already match the new (cnt, sel) pair.
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // otherwise a path that skips it would infer a latch.
        cnt_nxt    = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        sel_nxt    = sel;
        frame_edge = 1'b0;
        if (cnt == CNT_MAX) begin
            // Explicit wrap: for non-power-of-2 DIGITS sel must never pass SEL_MAX.
            sel_nxt    = (sel == SEL_MAX) ? '0 : sel + SW'(1);
            frame_edge = (sel == SEL_MAX);
        end

        shadow_nxt = frame_edge ? SEG_IN : shadow;
        blank_nxt  = (cnt_nxt < BLANK_C) || !DIGIT_EN[sel_nxt];

        anode_nxt = ANODE_IDLE;
        seg_lit   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_nxt == SW'(i)) begin
                anode_nxt[i] = ~ANODE_ACTIVE_LOW;
                seg_lit      = shadow_nxt[i*SEG_W +: SEG_W];
            end
        end

        if (blank_nxt) begin
            anode_nxt = ANODE_IDLE;
        end
        seg_nxt = blank_nxt ? SEG_IDLE : seg_lit;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            sel       <= '0;
            // The shadow tracks SEG_IN while reset is held, so the first frame
            // after release shows the data present at release.
            shadow    <= SEG_IN;
            ANODE     <= ANODE_IDLE;
            SEG_OUT   <= SEG_IDLE;
            FRAME_STB <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            sel       <= sel_nxt;
            shadow    <= shadow_nxt;
            ANODE     <= anode_nxt;
            SEG_OUT   <= seg_nxt;
            FRAME_STB <= frame_edge;
        end
    end

endmodule

// File: tb/tb_dynamic_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_dynamic_scan_controller
//
// Drives a 4-digit and a 3-digit scanner (DIV=8, BLANK=2, active-low outputs)
// from shared stimulus. The reference model counts edges since the last reset
// and derives digit, slot position and frame number by plain division; frame
// data is latched whenever a new frame begins. Expected outputs are queued per
// edge and a separate monitor compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_dynamic_scan_controller;

    localparam int DIV_T   = 8;
    localparam int BLANK_T = 2;

    typedef struct {
        logic [3:0] anode;
        logic [7:0] seg;
        logic [1:0] sel;
        logic       stb;
        int         t;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic [3:0]  DIGIT_EN;
    logic [31:0] SEG_IN;

    logic [1:0]  sel4;
    logic [3:0]  anode4;
    logic [7:0]  seg4;
    logic        stb4;

    logic [1:0]  sel3;
    logic [2:0]  anode3;
    logic [7:0]  seg3;
    logic        stb3;

    exp_t        q4[$];
    exp_t        q3[$];
    int          tm[2];
    logic [31:0] fd[2];

    int n_cmp = 0;
    int n_bad = 0;

    dynamic_scan_controller #(
        .DIGITS(4), .DIV(DIV_T), .BLANK(BLANK_T), .SEG_W(8),
        .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut4 (
        .CLK       (CLK),
        .RST       (RST),
        .DIGIT_EN  (DIGIT_EN),
        .SEG_IN    (SEG_IN),
        .SEL       (sel4),
        .ANODE     (anode4),
        .SEG_OUT   (seg4),
        .FRAME_STB (stb4)
    );

    dynamic_scan_controller #(
        .DIGITS(3), .DIV(DIV_T), .BLANK(BLANK_T), .SEG_W(8),
        .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut3 (
        .CLK       (CLK),
        .RST       (RST),
        .DIGIT_EN  (DIGIT_EN[2:0]),
        .SEG_IN    (SEG_IN[23:0]),
        .SEL       (sel3),
        .ANODE     (anode3),
        .SEG_OUT   (seg3),
        .FRAME_STB (stb3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected outputs t edges after reset release for a scanner of 'digits'.
    function automatic exp_t expect_at(input int digits, input int t, input logic [3:0] en,
                                       input logic [31:0] frame, input bit stb);
        exp_t       e;
        int         pos;
        int         dig;
        bit         blank;
        logic [3:0] all_off;
        pos     = t % DIV_T;
        dig     = (t / DIV_T) % digits;
        all_off = 4'((1 << digits) - 1);
        blank   = (pos < BLANK_T) || !en[dig];
        e.sel   = 2'(dig);
        e.stb   = stb;
        e.anode = blank ? all_off : (all_off & ~4'(1 << dig));
        e.seg   = blank ? 8'hFF : frame[dig*8 +: 8];
        e.t     = t;
        return e;
    endfunction

    // Apply inputs for one rising edge, queue what each DUT must show after it.
    task automatic step(input bit rst, input logic [3:0] en, input logic [31:0] seg);
        exp_t        e;
        int          digits;
        bit          stb;
        logic [31:0] segk;
        RST      = rst;
        DIGIT_EN = en;
        SEG_IN   = seg;
        for (int k = 0; k < 2; k++) begin
            digits = (k == 0) ? 4 : 3;
            segk   = (k == 0) ? seg : {8'h00, seg[23:0]};
            stb    = 1'b0;
            if (rst) begin
                tm[k]   = 0;
                fd[k]   = segk;
                e.anode = 4'((1 << digits) - 1);
                e.seg   = 8'hFF;
                e.sel   = 2'd0;
                e.stb   = 1'b0;
                e.t     = 0;
            end else begin
                tm[k]++;
                if (tm[k] % (digits * DIV_T) == 0) begin
                    stb   = 1'b1;
                    fd[k] = segk;
                end
                e = expect_at(digits, tm[k], en, fd[k], stb);
            end
            if (k == 0) q4.push_back(e);
            else        q3.push_back(e);
        end
        @(negedge CLK);
    endtask

    // Monitor: one output set per edge for each DUT, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check($sformatf("d4 anode t=%0d", e.t), {28'b0, anode4}, {28'b0, e.anode});
                check($sformatf("d4 seg t=%0d", e.t),   {24'b0, seg4},   {24'b0, e.seg});
                check($sformatf("d4 sel t=%0d", e.t),   {30'b0, sel4},   {30'b0, e.sel});
                check($sformatf("d4 stb t=%0d", e.t),   {31'b0, stb4},   {31'b0, e.stb});
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check($sformatf("d3 anode t=%0d", e.t), {29'b0, anode3}, {28'b0, e.anode});
                check($sformatf("d3 seg t=%0d", e.t),   {24'b0, seg3},   {24'b0, e.seg});
                check($sformatf("d3 sel t=%0d", e.t),   {30'b0, sel3},   {30'b0, e.sel});
                check($sformatf("d3 stb t=%0d", e.t),   {31'b0, stb3},   {31'b0, e.stb});
            end
        end
    end

    initial begin
        logic [3:0]  en;
        logic [31:0] seg;
        RST      = 1'b1;
        DIGIT_EN = 4'hF;
        SEG_IN   = 32'h11223344;

        // Reset held, then release and free-run two full 4-digit frames.
        repeat (3) step(1'b1, 4'hF, 32'h11223344);
        repeat (64) step(1'b0, 4'hF, 32'h11223344);

        // New data arrives mid-frame while digit 1 is lit.
        for (int i = 0; i < 64 && !(((tm[0] / DIV_T) % 4 == 1) && (tm[0] % DIV_T == 3)); i++)
            step(1'b0, 4'hF, 32'h11223344);
        seg = 32'hAABBCCDD;
        repeat (64) step(1'b0, 4'hF, seg);

        // Digits 0 and 2 disabled.
        repeat (64) step(1'b0, 4'b1010, seg);

        // Reset pulse aborting slot 2 at cnt=5.
        for (int i = 0; i < 64 && (tm[0] % (4 * DIV_T) != 2 * DIV_T + 5); i++)
            step(1'b0, 4'hF, seg);
        step(1'b1, 4'hF, seg);
        repeat (40) step(1'b0, 4'hF, seg);

        // Random enables, data and occasional resets.
        en = 4'hF;
        repeat (400) begin
            if ($urandom_range(0, 7) == 0)  en  = 4'($urandom);
            if ($urandom_range(0, 39) == 0) seg = $urandom;
            step($urandom_range(0, 99) < 2, en, seg);
        end

        check("queues drained", q4.size() + q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
